// File: rtl/resdmac_pkg.sv
// Shared types and constants for the RESDMAC DMA address generator.
package resdmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MASTER   = 3'd1,
        ST_CYCLE    = 3'd2,
        ST_TERM     = 3'd3,
        ST_TERM_ERR = 3'd4
    } dma_state_e;

    localparam logic [4:0] ACR_OFFSET = 5'h03;
    localparam logic [2:0] INC_LONG   = 3'd4;
    localparam logic [2:0] INC_WORD   = 3'd2;

    // Bytes moved by a terminated cycle; STERM means a 32-bit synchronous
    // port, so DSACK sizing is ignored when STERM is asserted.
    function automatic logic [2:0] calc_inc(input logic sterm_b,
                                            input logic siz1,
                                            input logic [1:0] dsack_b);
        if (!sterm_b)
            return siz1 ? INC_WORD : INC_LONG;
        else
            return (siz1 || (dsack_b == 2'b01)) ? INC_WORD : INC_LONG;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser with rise/fall pulses on the synchronised level.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    // Shift chain: meta -> sync -> delayed copy for edge detection.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Idle-high strobes, so everything resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~dly_q;
    assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/dma_addr_gen.sv
// DMA address counter (ACR): CPU load/readback, drives the address bus while
// RESDMAC is master and advances by the size of each terminated cycle.
module dma_addr_gen
    import resdmac_pkg::*;
#(
    parameter logic [4:0] ACR_OFFSET = resdmac_pkg::ACR_OFFSET,
    parameter int         ADDR_W     = 32
) (
    input  logic              SCLK,
    input  logic              _RST,
    input  logic              _CS,
    input  logic              R_W,
    input  logic              _AS,
    input  logic              _DS,
    input  logic [4:0]        ADDR,
    input  logic [ADDR_W-1:0] DATA_I,
    output logic [ADDR_W-1:0] DATA_O,
    output logic              DATA_OE,
    input  logic              _DMAEN,
    input  logic              SIZ1,
    input  logic [1:0]        _DSACK,
    input  logic              _STERM,
    input  logic              _BERR,
    output logic [ADDR_W-1:0] A_O,
    output logic              A_OE,
    output logic              ACR_A1,
    output logic              BERR_FLAG
);

    logic as_s, as_rise, as_fall;
    logic ds_s, ds_rise, ds_fall;

    edge_sync u_as_sync (.clk(SCLK), .rst_n(_RST), .d(_AS), .q(as_s), .rise(as_rise), .fall(as_fall));
    edge_sync u_ds_sync (.clk(SCLK), .rst_n(_RST), .d(_DS), .q(ds_s), .rise(ds_rise), .fall(ds_fall));

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] acr_q, acr_d;
    logic [2:0]        inc_q, inc_d;
    logic              berr_q, berr_d;
    logic              wr_done_q, wr_done_d;

    logic acr_sel, cpu_wr_qual;
    assign acr_sel     = ~_CS & (ADDR == ACR_OFFSET);
    assign cpu_wr_qual = acr_sel & ~R_W & _DMAEN;

    // Next-state: CPU load, bus-master sequencing and ACR advance.
    always_comb begin
        state_d   = state_q;
        acr_d     = acr_q;
        inc_d     = inc_q;
        berr_d    = berr_q;
        wr_done_d = wr_done_q;

        // wr_done limits the load to one per address strobe.
        if (cpu_wr_qual && !ds_s && !wr_done_q) begin
            acr_d     = {DATA_I[ADDR_W-1:1], 1'b0};
            berr_d    = 1'b0;
            wr_done_d = 1'b1;
        end
        if (as_rise)
            wr_done_d = 1'b0;

        if (_DMAEN) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_MASTER;
                ST_MASTER: if (as_fall) state_d = ST_CYCLE;
                ST_CYCLE: begin
                    if (!_BERR) begin
                        berr_d  = 1'b1;
                        state_d = ST_TERM_ERR;
                    end else if (!_STERM || (_DSACK != 2'b11)) begin
                        inc_d   = calc_inc(_STERM, SIZ1, _DSACK);
                        state_d = ST_TERM;
                    end
                end
                ST_TERM: if (as_rise) begin
                    acr_d   = acr_q + {{(ADDR_W-3){1'b0}}, inc_q};
                    state_d = ST_MASTER;
                end
                ST_TERM_ERR: if (as_rise) state_d = ST_MASTER;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State, counter and flag registers.
    always_ff @(posedge SCLK or negedge _RST) begin
        if (!_RST) begin
            state_q   <= ST_IDLE;
            acr_q     <= '0;
            inc_q     <= INC_LONG;
            berr_q    <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acr_q     <= acr_d;
            inc_q     <= inc_d;
            berr_q    <= berr_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign DATA_OE   = acr_sel & ~_AS & R_W;
    assign DATA_O    = DATA_OE ? acr_q : '0;
    assign A_OE      = ~_DMAEN;
    assign A_O       = acr_q;
    assign ACR_A1    = acr_q[1];
    assign BERR_FLAG = berr_q;

    // Bit 0 of the data bus and some sync outputs have no use here.
    logic unused_sig;
    assign unused_sig = ^{DATA_I[0], as_s, ds_rise, ds_fall};

endmodule

// File: doc/dma_addr_gen.md
# dma_addr_gen

DMA address generator that sits directly downstream of the RESDMAC bus-master logic. It replaces the Ramsey-side address counter:
- holds the DMA address counter register (ACR), loaded and read back by the CPU;
- drives the 32-bit address bus whenever RESDMAC owns the bus (`_DMAEN` low);
- advances the address by the byte count of each successfully terminated DMA bus cycle.

## Interface
Parameters:
- ACR_OFFSET, 5'h03, value of ADDR[6:2] that selects the ACR (byte offset 0x0C).
- ADDR_W, 32, address and ACR width.

Ports:
- SCLK  in  1  CPU clock (CPUCLKB); the only clock.
- _RST  in  1  system reset; asynchronous, active-low.
- _CS  in  1  SDMAC chip select from Fat Garry, active-low.
- R_W  in  1  CPU read/write; 1 = read.
- _AS  in  1  address strobe (CPU or RESDMAC), active-low.
- _DS  in  1  data strobe, active-low.
- ADDR  in  5  CPU address bits [6:2].
- DATA_I  in  32  CPU data bus in, used for ACR writes.
- DATA_O  out  32  ACR readback value.
- DATA_OE  out  1  high while an ACR read is driving DATA_O.
- _DMAEN  in  1  low = RESDMAC is bus master.
- SIZ1  in  1  1 = 16-bit DMA transfer requested.
- _DSACK  in  2  DSACK[1:0] from the bus, active-low.
- _STERM  in  1  synchronous termination, active-low.
- _BERR  in  1  bus error, active-low.
- A_O  out  32  DMA address; always equal to ACR.
- A_OE  out  1  address bus output enable.
- ACR_A1  out  1  ACR bit 1, fed to the registers and CPU state machine as A1.
- BERR_FLAG  out  1  sticky flag: a DMA cycle ended in bus error.

## Operation
**Synchronisation.** `_AS` and `_DS` each pass through a 2-flop synchroniser on SCLK, with rising and falling edge detection.

**CPU ACR write.**
- Qualifier: `_CS`=0, R_W=0, ADDR==ACR_OFFSET and `_DMAEN`=1.
- Action: on the first SCLK with synchronised `_DS` low, ACR <= {DATA_I[31:1], 1'b0} and BERR_FLAG <= 0.
- The write happens exactly once per `_AS` assertion.

**CPU ACR read.**
- When `_CS`=0, `_AS`=0, R_W=1 and ADDR==ACR_OFFSET, DATA_OE=1 (combinational) and DATA_O=ACR.
- Otherwise DATA_OE=0 and DATA_O=0.

**Address output.**
- A_OE = ~`_DMAEN` (combinational). A_O = ACR. ACR_A1 = ACR[1].

**State machine.**
- IDLE: go to MASTER when `_DMAEN`=0.
- MASTER: go to CYCLE on the falling edge of synchronised `_AS`.
- CYCLE: sample the termination inputs every SCLK rising edge.
  - `_BERR`=0: set BERR_FLAG, go to TERM_ERR.
  - Else `_STERM`=0 or `_DSACK`!=2'b11: latch the increment amount, go to TERM.
- TERM: on the synchronised `_AS` rising edge, ACR <= ACR + inc and go to MASTER.
- TERM_ERR: on the synchronised `_AS` rising edge, go to MASTER with no increment.
- Any state: `_DMAEN`=1 returns the machine to IDLE next cycle. Leaving CYCLE or TERM this way aborts the cycle and the ACR is not incremented.

**Increment amount.**
- 2 if SIZ1=1 or `_DSACK`==2'b01 (16-bit port).
- 4 otherwise (32-bit port or `_STERM`).
- `_STERM` takes priority over `_DSACK` when both are asserted.

**Arithmetic.**
- 32-bit unsigned, wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Bit 0 is always 0.
- A +2 from A1=1 carries into bit 2.

**Priorities.**
- `_BERR` together with DSACK/STERM: `_BERR` wins, no increment.
- A CPU write while `_DMAEN`=0 is ignored.

## Timing
**Reset values** (asynchronous assert, synchronous release on SCLK):
- ACR=0, state IDLE, BERR_FLAG=0, synchronisers=1.
- Resulting outputs: DATA_O=0, DATA_OE=0, A_O=0, ACR_A1=0. A_OE follows `_DMAEN`.

**Latencies.**
- Write: ACR holds the new value 1 SCLK after the qualifying `_DS` sample, i.e. 3 SCLK after the `_DS` falling edge including synchronisation.
- Increment: visible on A_O 1 SCLK after the `_AS` rising edge is detected, i.e. at most 3 SCLK after `_AS` rises.
- Required of the CPU state machine: at least 3 SCLK of `_AS` high between DMA cycles.

**Reset mid-cycle:** immediate return to reset values; the partial cycle is discarded.

## Structure
- Package `resdmac_pkg`: state enum (IDLE, MASTER, CYCLE, TERM, TERM_ERR), ACR_OFFSET, INC_LONG=4, INC_WORD=2.
- Sub-module `edge_sync`: 2-flop synchroniser plus rise/fall pulses. Instantiated for `_AS` and `_DS`.

## Test plan
- **Reset then write:** reset, then CPU write 32'h0012_3457 to offset 0x0C -> ACR=32'h0012_3456, read back 32'h0012_3456 with DATA_OE=1.
- **Long DMA cycles:** ACR=32'h0000_1000, `_DMAEN`=0, three long cycles terminated by `_STERM` -> A_O sequence 1000, 1004, 1008, 100C.
- **16-bit and wrap:** two cycles with SIZ1=1 from 32'hFFFF_FFFE -> A_O=0 then 2, ACR_A1 toggles 1->0->1.
- **Bus error:** cycle terminated with `_BERR`=0 and `_DSACK`=2'b00 -> ACR unchanged, BERR_FLAG=1; next CPU ACR write clears it.
- **Abort:** `_DMAEN` deasserted while in CYCLE -> no increment, state IDLE, A_OE=0; a CPU write attempted while `_DMAEN`=0 leaves ACR unchanged.
- **Reset mid-cycle:** `_RST` pulsed low in TERM with ACR=32'h0000_2000 -> ACR=0, BERR_FLAG=0; after release the next cycle starts from 0.
